// File: rtl/chip_idle_ctrl.sv
// Chip-level idle detector: merges CPU, cache-bank and external busy sources,
// debounces the idle condition, and runs the sleep request / acknowledge handshake with the PMU.
module chip_idle_ctrl #(
    parameter int N_CPU  = 5,
    parameter int N_BANK = 4,
    parameter int N_EXT  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CPU-1:0]  cpu_wfi,
    input  logic [N_CPU-1:0]  cpu_wfe,
    input  logic [N_CPU-1:0]  cpu_rstn,
    input  logic [N_CPU-1:0]  cpu_mask,
    input  logic [N_BANK-1:0] bank_idle,
    input  logic [N_BANK-1:0] bank_rstn,
    input  logic [N_BANK-1:0] bank_mask,
    input  logic [N_EXT-1:0]  ext_busy,
    input  logic [CNT_W-1:0]  idle_thresh,
    input  logic              sleep_ack,
    output logic              sleep_req,
    output logic              chip_is_idle,
    output logic              raw_idle,
    output logic [CNT_W-1:0]  idle_cnt,
    output logic              wake_pulse,
    output logic              abort_pulse
);

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_COUNT,
        ST_REQ,
        ST_IDLE,
        ST_WAKE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              sleep_req_q, chip_is_idle_q, wake_pulse_q, abort_pulse_q;
    logic              wake_pulse_d, abort_pulse_d;
    logic [N_CPU-1:0]  cpu_busy;
    logic [N_BANK-1:0] bank_busy;
    logic              go;

    // A source in reset or masked can never hold the chip awake.
    assign cpu_busy  = ~cpu_wfi & ~cpu_wfe & cpu_rstn & ~cpu_mask;
    assign bank_busy = ~bank_idle & bank_rstn & ~bank_mask;
    assign raw_idle  = ~(|cpu_busy) & ~(|bank_busy) & ~(|ext_busy);
    assign go        = en & raw_idle;

    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        wake_pulse_d  = 1'b0;
        abort_pulse_d = 1'b0;
        unique case (state_q)
            ST_ACTIVE: begin
                idle_cnt_d = '0;
                if (go) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (!go) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= idle_thresh) begin
                    state_d = ST_REQ;
                end else begin
                    idle_cnt_d = idle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_REQ: begin
                // An acknowledge already in flight wins over a late busy.
                if (sleep_ack) begin
                    state_d = ST_IDLE;
                end else if (!go) begin
                    state_d       = ST_ACTIVE;
                    idle_cnt_d    = '0;
                    abort_pulse_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (!go) begin
                    state_d      = ST_WAKE;
                    wake_pulse_d = 1'b1;
                end
            end
            ST_WAKE: begin
                if (!sleep_ack) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_ACTIVE;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ACTIVE;
            idle_cnt_q     <= '0;
            sleep_req_q    <= 1'b0;
            chip_is_idle_q <= 1'b0;
            wake_pulse_q   <= 1'b0;
            abort_pulse_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_cnt_q     <= idle_cnt_d;
            sleep_req_q    <= (state_d == ST_REQ) || (state_d == ST_IDLE);
            chip_is_idle_q <= (state_d == ST_IDLE);
            wake_pulse_q   <= wake_pulse_d;
            abort_pulse_q  <= abort_pulse_d;
        end
    end

    assign sleep_req    = sleep_req_q;
    assign chip_is_idle = chip_is_idle_q;
    assign idle_cnt     = idle_cnt_q;
    assign wake_pulse   = wake_pulse_q;
    assign abort_pulse  = abort_pulse_q;

endmodule
